data_sync_hs: RTL and testbench
===============================

Name: data_sync_hs

Overview:
- Destination-domain data synchronizer for multi-bit buses crossing from a slower or unrelated clock domain.
- The source holds `unsync_bus` stable and signals a transfer on `bus_enable`.
- The block synchronizes `bus_enable` through a configurable flop chain and detects the transfer event in level (4-phase) or toggle (2-phase) mode.
- On each event it captures the bus, emits a one-cycle pulse, holds the word under a valid/ready handshake, returns an ack level for the source, and flags overruns.

Parameters:
- BUS_WIDTH, 8, width of `unsync_bus` and `sync_bus`.
- NUM_STAGES, 2, synchronizer flop count on `bus_enable`; legal range >= 2; elaboration error otherwise.
- TOGGLE_MODE, 0, selects the event definition: 0 = level mode (event on rising edge of synced enable), 1 = toggle mode (event on any change of synced enable).

Ports:
- CLK  input  1  destination clock.
- RST  input  1  asynchronous reset, active-low.
- unsync_bus  input  BUS_WIDTH  source-domain data; stable from before `bus_enable` changes until ack observed.
- bus_enable  input  1  source-domain transfer request, level or toggle per TOGGLE_MODE.
- sync_bus  output  BUS_WIDTH  captured data, registered.
- enable_pulse  output  1  one-CLK-cycle pulse per captured transfer.
- sync_valid  output  1  captured word awaiting consumer.
- sync_ready  input  1  consumer accepts word when `sync_valid` & `sync_ready`.
- ack  output  1  synchronized enable level, returned to the source domain (source re-synchronizes it).
- overrun  output  1  sticky flag; a new transfer overwrote an unaccepted word.
- clr_overrun  input  1  clears `overrun`.

Behaviour:
- All state is reset asynchronously, active-low, on CLK rising edge otherwise.
  - Reset values: `sync_bus`=0, `enable_pulse`=0, `sync_valid`=0, `ack`=0, `overrun`=0, synchronizer chain=0, `en_prev`=0.
- Synchronizer chain:
  - `s[0]` <= `bus_enable`; `s[i]` <= `s[i-1]`; `en_sync` = `s[NUM_STAGES-1]`.
  - `en_prev` <= `en_sync`.
  - `ack` = `en_prev`, a registered output driven straight from the flop.
- Event definition, combinational:
  - TOGGLE_MODE=0: `event` = `en_sync` & ~`en_prev`.
  - TOGGLE_MODE=1: `event` = `en_sync` ^ `en_prev`.
- On the edge where `event`=1:
  - `sync_bus` <= `unsync_bus`.
  - `enable_pulse` <= 1.
  - `sync_valid` <= 1.
- Otherwise:
  - `enable_pulse` <= 0.
  - `sync_bus` holds; it never changes except on an event.
- Latency: count the edge that first samples the changed `bus_enable` as edge 0.
  - `enable_pulse`, `sync_bus` and `sync_valid` update on edge NUM_STAGES.
  - `ack` updates on the same edge NUM_STAGES.
  - With NUM_STAGES=2, the pulse is high between edges 2 and 3.
- Handshake, consumer side:
  - `sync_valid` clears on an edge where `sync_valid` & `sync_ready` and no event.
  - Event and accept on the same edge: `sync_valid` stays 1 and the new data is loaded. This is not an overrun.
  - `sync_ready` while `sync_valid`=0 has no effect.
- Overrun:
  - Event while `sync_valid`=1 and `sync_ready`=0: `overrun` <= 1 and the new data overwrites `sync_bus` (newest wins). `sync_valid` stays 1.
  - `overrun` is sticky until `clr_overrun`=1 at an edge.
  - Same-edge set and clear: set wins.
- Source protocol, level mode:
  - Raise `bus_enable`, wait `ack`=1, drop `bus_enable`, wait `ack`=0 before the next transfer.
  - Re-raising `bus_enable` before it is seen low produces no event.
- Source protocol, toggle mode:
  - Flip `bus_enable` per transfer; next flip only after `ack` equals the new level.
- Glitch tolerance: a `bus_enable` level shorter than one CLK period may be missed. This is a source protocol violation, not detected.
- Reset mid-operation:
  - Chain and `en_prev` clear and any pending word is lost; `sync_valid` returns to 0.
  - If `bus_enable`=1 on reset release, in either mode, one event is detected NUM_STAGES edges later and the data is re-captured.
  - Sources must be reset together with this block.
- Data qualification: no path from `unsync_bus` to a flop other than `sync_bus` capture. `unsync_bus` is sampled only on event edges.

Test Plan:
- Level single transfer, NUM_STAGES=2, `sync_ready`=1: `unsync_bus`=0xA5, `bus_enable` 0→1 sampled at edge 0 -> `enable_pulse`=1 for exactly one cycle after edge 2, `sync_bus`=0xA5, `ack`=1 after edge 2. Drop enable -> `ack`=0 two edges later, no second pulse.
- Backpressure/overrun: `sync_ready`=0, transfer 0x11 then 0x22 -> `sync_valid`=1, `sync_bus`=0x22, `overrun`=1. `clr_overrun` pulse -> `overrun`=0. `sync_ready`=1 one cycle -> `sync_valid`=0.
- Same-edge accept and event: `sync_valid`=1 with 0x33, `sync_ready`=1 on the edge a new 0x44 event captures -> `sync_valid` stays 1, `sync_bus`=0x44, `overrun`=0.
- Toggle mode, NUM_STAGES=3: four toggles carrying 0x01..0x04, each after `ack` matches -> four pulses, each 3 edges after sampling, data in order, `overrun`=0.
- Reset mid-transfer: assert RST while the enable is in the chain -> all outputs 0 immediately. Release with `bus_enable`=1 -> one pulse at edge NUM_STAGES after release.
- Protocol violation, level mode: `bus_enable` held high across two intended transfers -> exactly one pulse, `sync_bus` holds first capture.

Source files
------------

// File: rtl/data_sync_hs_if.sv
// data_sync_hs_if
// Bundles the source/consumer-facing signals of data_sync_hs.
//   master : the environment (source drives unsync_bus/bus_enable, consumer
//            drives sync_ready/clr_overrun, both observe the outputs)
//   slave  : the synchronizer block itself
// Signals:
//   unsync_bus   source data, held stable until ack is observed
//   bus_enable   transfer request (level or toggle)
//   sync_bus     captured word
//   enable_pulse one-cycle pulse per captured transfer
//   sync_valid   captured word awaiting the consumer
//   sync_ready   consumer accepts word when sync_valid & sync_ready
//   ack          synchronized enable level returned to the source
//   overrun      sticky flag: an unaccepted word was overwritten
//   clr_overrun  clears overrun
interface data_sync_hs_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic                 enable_pulse;
  logic                 sync_valid;
  logic                 sync_ready;
  logic                 ack;
  logic                 overrun;
  logic                 clr_overrun;

  modport master (
    output unsync_bus, bus_enable, sync_ready, clr_overrun,
    input  sync_bus, enable_pulse, sync_valid, ack, overrun
  );

  modport slave (
    input  unsync_bus, bus_enable, sync_ready, clr_overrun,
    output sync_bus, enable_pulse, sync_valid, ack, overrun
  );
endinterface

// File: rtl/data_sync_hs.sv
// data_sync_hs
// Destination-domain synchronizer for a multi-bit bus. bus_enable passes
// through a NUM_STAGES flop chain; a transfer event (rising edge in level
// mode, any change in toggle mode) captures unsync_bus into sync_bus, emits
// a one-cycle enable_pulse and raises sync_valid until the consumer accepts.
// ack returns the synchronized enable level to the source. overrun is set
// when a new event overwrites an unaccepted word.
// Ports:
//   CLK  destination clock
//   RST  asynchronous reset, active-low
//   bus  data_sync_hs_if.slave (see interface for signal list)
module data_sync_hs #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_STAGES  = 2,
  parameter bit          TOGGLE_MODE = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  data_sync_hs_if.slave     bus
);

  generate
    if (NUM_STAGES < 32'd2) begin : g_bad_stages
      $error("data_sync_hs: NUM_STAGES must be >= 2");
    end
  endgenerate

  logic [NUM_STAGES-1:0] sync_chain_r;
  logic                  en_sync_s;
  logic                  en_prev_r;
  logic                  xfer_event_s;

  logic [BUS_WIDTH-1:0]  sync_bus_r;
  logic                  enable_pulse_r;
  logic                  sync_valid_r;
  logic                  overrun_r;

  logic [BUS_WIDTH-1:0]  sync_bus_nxt_s;
  logic                  sync_valid_nxt_s;
  logic                  overrun_nxt_s;

  assign en_sync_s = sync_chain_r[NUM_STAGES-1];

  generate
    if (TOGGLE_MODE) begin : g_toggle
      assign xfer_event_s = en_sync_s ^ en_prev_r;
    end else begin : g_level
      assign xfer_event_s = en_sync_s & ~en_prev_r;
    end
  endgenerate

  // Enable synchronizer chain and previous-level register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_chain_r <= {NUM_STAGES{1'b0}};
      en_prev_r    <= 1'b0;
    end else begin
      sync_chain_r <= {sync_chain_r[NUM_STAGES-2:0], bus.bus_enable};
      en_prev_r    <= en_sync_s;
    end
  end

  // Next-state for captured data, valid and overrun.
  always_comb begin
    sync_bus_nxt_s   = sync_bus_r;
    sync_valid_nxt_s = sync_valid_r;
    overrun_nxt_s    = overrun_r;

    // unsync_bus is only looked at on an event, so it is qualified by the
    // synchronized enable and never reaches any other flop.
    if (xfer_event_s) begin
      sync_bus_nxt_s   = bus.unsync_bus;
      sync_valid_nxt_s = 1'b1;
    end else if (sync_valid_r && bus.sync_ready) begin
      sync_valid_nxt_s = 1'b0;
    end else begin
      sync_valid_nxt_s = sync_valid_r;
    end

    // Set beats clear when both happen on the same edge.
    if (xfer_event_s && sync_valid_r && !bus.sync_ready) begin
      overrun_nxt_s = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_nxt_s = 1'b0;
    end else begin
      overrun_nxt_s = overrun_r;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_bus_r     <= {BUS_WIDTH{1'b0}};
      enable_pulse_r <= 1'b0;
      sync_valid_r   <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      sync_bus_r     <= sync_bus_nxt_s;
      enable_pulse_r <= xfer_event_s;
      sync_valid_r   <= sync_valid_nxt_s;
      overrun_r      <= overrun_nxt_s;
    end
  end

  assign bus.sync_bus     = sync_bus_r;
  assign bus.enable_pulse = enable_pulse_r;
  assign bus.sync_valid   = sync_valid_r;
  assign bus.overrun      = overrun_r;
  assign bus.ack          = en_prev_r;

endmodule

// File: tb/tb_data_sync_hs.sv
// tb_data_sync_hs
// Directed bench for data_sync_hs. Two instances share CLK/RST:
//   u_lvl : level mode, NUM_STAGES=2
//   u_tgl : toggle mode, NUM_STAGES=3
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_data_sync_hs;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  data_sync_hs_if #(.BUS_WIDTH(8)) ifl ();
  data_sync_hs_if #(.BUS_WIDTH(8)) ift ();

  data_sync_hs #(.BUS_WIDTH(8), .NUM_STAGES(2), .TOGGLE_MODE(1'b0)) u_lvl (
    .CLK (CLK),
    .RST (RST),
    .bus (ifl)
  );

  data_sync_hs #(.BUS_WIDTH(8), .NUM_STAGES(3), .TOGGLE_MODE(1'b1)) u_tgl (
    .CLK (CLK),
    .RST (RST),
    .bus (ift)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt_l = 0;
  int pulse_cnt_t = 0;
  int base_l;
  int base_t;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (ifl.enable_pulse) pulse_cnt_l <= pulse_cnt_l + 1;
    if (ift.enable_pulse) pulse_cnt_t <= pulse_cnt_t + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Full 4-phase transfer on the level-mode instance with bounded waits.
  task automatic level_xfer(input logic [7:0] d);
    int n;
    ifl.unsync_bus = d;
    ifl.bus_enable = 1'b1;
    n = 0;
    while (ifl.ack !== 1'b1 && n < 20) begin tick(); n++; end
    check("lvl_ack_rise", ifl.ack, 1);
    ifl.bus_enable = 1'b0;
    n = 0;
    while (ifl.ack !== 1'b0 && n < 20) begin tick(); n++; end
    check("lvl_ack_fall", ifl.ack, 0);
  endtask

  initial begin
    ifl.unsync_bus = 8'h00; ifl.bus_enable = 1'b0; ifl.sync_ready = 1'b0; ifl.clr_overrun = 1'b0;
    ift.unsync_bus = 8'h00; ift.bus_enable = 1'b0; ift.sync_ready = 1'b1; ift.clr_overrun = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_sync_bus", ifl.sync_bus, 0);
    check("rst_pulse",    ifl.enable_pulse, 0);
    check("rst_valid",    ifl.sync_valid, 0);
    check("rst_ack",      ifl.ack, 0);
    check("rst_overrun",  ifl.overrun, 0);
    check("rst_t_valid",  ift.sync_valid, 0);
    RST = 1'b1;
    tick();

    // Level single transfer, exact latency
    ifl.sync_ready = 1'b1;
    ifl.unsync_bus = 8'hA5;
    ifl.bus_enable = 1'b1;
    tick(); // edge 0
    check("t1_e0_pulse", ifl.enable_pulse, 0);
    tick(); // edge 1
    check("t1_e1_pulse", ifl.enable_pulse, 0);
    check("t1_e1_ack",   ifl.ack, 0);
    tick(); // edge 2
    check("t1_e2_pulse", ifl.enable_pulse, 1);
    check("t1_e2_bus",   ifl.sync_bus, 8'hA5);
    check("t1_e2_ack",   ifl.ack, 1);
    check("t1_e2_valid", ifl.sync_valid, 1);
    tick(); // edge 3
    check("t1_e3_pulse", ifl.enable_pulse, 0);
    check("t1_e3_valid", ifl.sync_valid, 0);
    base_l = pulse_cnt_l;
    ifl.bus_enable = 1'b0;
    tick(); // edge 0
    check("t1_fall_e0_ack", ifl.ack, 1);
    tick();
    check("t1_fall_e1_ack", ifl.ack, 1);
    tick();
    check("t1_fall_e2_ack", ifl.ack, 0);
    tick(); tick();
    check("t1_no_second_pulse", pulse_cnt_l - base_l, 0);
    check("t1_bus_hold", ifl.sync_bus, 8'hA5);

    // Backpressure and overrun
    ifl.sync_ready = 1'b0;
    base_l = pulse_cnt_l;
    level_xfer(8'h11);
    check("t2_valid_first", ifl.sync_valid, 1);
    check("t2_ovr_first",   ifl.overrun, 0);
    level_xfer(8'h22);
    check("t2_pulses",  pulse_cnt_l - base_l, 2);
    check("t2_valid",   ifl.sync_valid, 1);
    check("t2_bus",     ifl.sync_bus, 8'h22);
    check("t2_overrun", ifl.overrun, 1);
    tick();
    check("t2_ovr_sticky", ifl.overrun, 1);
    ifl.clr_overrun = 1'b1;
    tick();
    ifl.clr_overrun = 1'b0;
    check("t2_ovr_clr", ifl.overrun, 0);
    check("t2_valid_kept", ifl.sync_valid, 1);
    ifl.sync_ready = 1'b1;
    tick();
    ifl.sync_ready = 1'b0;
    check("t2_accept", ifl.sync_valid, 0);

    // Same-edge accept and event
    level_xfer(8'h33);
    check("t3_valid33", ifl.sync_valid, 1);
    check("t3_bus33",   ifl.sync_bus, 8'h33);
    ifl.unsync_bus = 8'h44;
    ifl.bus_enable = 1'b1;
    tick(); // edge 0
    tick(); // edge 1
    ifl.sync_ready = 1'b1;
    tick(); // edge 2: event and accept together
    ifl.sync_ready = 1'b0;
    check("t3_pulse",   ifl.enable_pulse, 1);
    check("t3_valid",   ifl.sync_valid, 1);
    check("t3_bus44",   ifl.sync_bus, 8'h44);
    check("t3_overrun", ifl.overrun, 0);
    level_xfer(8'h44); // enable already high: completes the handshake only
    ifl.sync_ready = 1'b1;
    tick();
    check("t3_drain", ifl.sync_valid, 0);

    // Protocol violation: enable held high across two intended transfers
    base_l = pulse_cnt_l;
    ifl.unsync_bus = 8'h55;
    ifl.bus_enable = 1'b1;
    repeat (4) tick();
    ifl.unsync_bus = 8'h66;
    repeat (6) tick();
    check("t6_one_pulse", pulse_cnt_l - base_l, 1);
    check("t6_bus_first", ifl.sync_bus, 8'h55);
    level_xfer(8'h66);
    check("t6_bus_still", ifl.sync_bus, 8'h55);

    // Toggle mode, NUM_STAGES=3
    base_t = pulse_cnt_t;
    for (int k = 1; k <= 4; k++) begin
      ift.unsync_bus = k[7:0];
      ift.bus_enable = ~ift.bus_enable;
      tick(); tick(); // edges 0,1
      check("t4_e1_pulse", ift.enable_pulse, 0);
      tick();         // edge 2
      check("t4_e2_pulse", ift.enable_pulse, 0);
      tick();         // edge 3
      check("t4_e3_pulse", ift.enable_pulse, 1);
      check("t4_bus",      ift.sync_bus, k);
      check("t4_ack",      ift.ack, ift.bus_enable);
      tick();
      check("t4_pulse_end", ift.enable_pulse, 0);
    end
    check("t4_pulses",  pulse_cnt_t - base_t, 4);
    check("t4_overrun", ift.overrun, 0);

    // Reset mid-operation
    ifl.sync_ready = 1'b0;
    ifl.unsync_bus = 8'h77;
    ifl.bus_enable = 1'b1;
    tick(); tick(); tick();
    check("t5_pre_valid", ifl.sync_valid, 1);
    check("t5_pre_bus",   ifl.sync_bus, 8'h77);
    #2;
    RST = 1'b0;
    #1;
    check("t5_rst_bus",   ifl.sync_bus, 0);
    check("t5_rst_valid", ifl.sync_valid, 0);
    check("t5_rst_ack",   ifl.ack, 0);
    check("t5_rst_pulse", ifl.enable_pulse, 0);
    check("t5_rst_t_bus", ift.sync_bus, 0);
    tick();
    ifl.unsync_bus = 8'h88;
    ift.unsync_bus = 8'h99;
    ift.bus_enable = 1'b1;
    RST = 1'b1;
    tick(); // edge 0
    tick(); // edge 1
    check("t5_e1_pulse", ifl.enable_pulse, 0);
    tick(); // edge 2
    check("t5_e2_pulse",   ifl.enable_pulse, 1);
    check("t5_e2_bus",     ifl.sync_bus, 8'h88);
    check("t5_e2_t_pulse", ift.enable_pulse, 0);
    tick(); // edge 3
    check("t5_e3_pulse",   ifl.enable_pulse, 0);
    check("t5_e3_t_pulse", ift.enable_pulse, 1);
    check("t5_e3_t_bus",   ift.sync_bus, 8'h99);
    tick();
    check("t5_t_pulse_end", ift.enable_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
